// File: rtl/mag_countdown_timer.sv
// Microwave MM:SS countdown timer. Keypad digits shift in from the right while idle,
// and the count runs down once per second while the magnetron is enabled.
module mag_countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mag_on,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_r;
  logic [15:0]   digits_r;
  logic          timer_done_r;
  logic          done_pulse_r;

  logic          load_ok_s;
  logic          run_s;
  logic          tick_s;
  logic [15:0]   dec_s;
  logic [15:0]   digits_nxt_s;
  logic [PW-1:0] presc_nxt_s;
  logic          pulse_nxt_s;

  // One-second BCD decrement of {min_tens, min_ones, sec_tens, sec_ones}. Seconds above 59
  // are left as entered; 00:00 is returned unchanged.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      so = 4'd9;
      st = st - 4'd1;
    end else if ({mt, mo} != 8'd0) begin
      so = 4'd9;
      st = 4'd5;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mo = 4'd9;
        mt = mt - 4'd1;
      end
    end else begin
      so = 4'd0;
    end
    return {mt, mo, st, so};
  endfunction

  assign load_ok_s = load && !mag_on && clearn && (digit <= 4'd9);
  assign run_s     = mag_on && !timer_done_r;
  assign tick_s    = run_s && (presc_r == PRESC_MAX);
  assign dec_s     = bcd_dec(digits_r);

  // Next-state selection: clear beats load beats the running count.
  always_comb begin
    digits_nxt_s = digits_r;
    presc_nxt_s  = presc_r;
    pulse_nxt_s  = 1'b0;
    if (!clearn) begin
      digits_nxt_s = 16'h0000;
      presc_nxt_s  = '0;
    end else if (load_ok_s) begin
      digits_nxt_s = {digits_r[11:0], digit};
      presc_nxt_s  = '0;
    end else if (tick_s) begin
      digits_nxt_s = dec_s;
      presc_nxt_s  = '0;
      pulse_nxt_s  = (dec_s == 16'h0000);
    end else if (run_s) begin
      presc_nxt_s  = presc_r + PW'(1);
    end else begin
      presc_nxt_s  = presc_r;
    end
  end

  // State and output registers; timer_done tracks the digits being loaded this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r      <= '0;
      digits_r     <= 16'h0000;
      timer_done_r <= 1'b1;
      done_pulse_r <= 1'b0;
    end else begin
      presc_r      <= presc_nxt_s;
      digits_r     <= digits_nxt_s;
      timer_done_r <= (digits_nxt_s == 16'h0000);
      done_pulse_r <= pulse_nxt_s;
    end
  end

  assign min_tens   = digits_r[15:12];
  assign min_ones   = digits_r[11:8];
  assign sec_tens   = digits_r[7:4];
  assign sec_ones   = digits_r[3:0];
  assign timer_done = timer_done_r;
  assign done_pulse = done_pulse_r;

endmodule

// File: doc/mag_countdown_timer.md
MAG_COUNTDOWN_TIMER -- requirements
Module: mag_countdown_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100, number of clk cycles per countdown second; legal range 2 to 2^24.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mag_on  input  1  magnetron-enable level from the magnetron control; high means cooking and the count runs.
REQ-005 clearn  input  1  synchronous clear, active-low.
REQ-006 load  input  1  keypad digit strobe, one cycle per key press.
REQ-007 digit  input  4  BCD keypad digit, qualified by load.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD remaining time, MM:SS.
REQ-009 timer_done  output  1  level, high whenever all four digits are zero; fed back to the magnetron control.
REQ-010 done_pulse  output  1  one-cycle pulse when a countdown reaches zero (buzzer trigger).

Function
REQ-011 All outputs registered; update priority: reset > clear > load > decrement.
REQ-012 Prescaler: counts 0..TICKS_PER_SEC-1 only while mag_on=1 and timer_done=0; at TICKS_PER_SEC-1 it wraps to 0 and issues a one-second tick in the same cycle.
REQ-013 Prescaler holds its value while mag_on=0 (pause keeps the partial second); cleared to 0 by reset, clear, and accepted load.
REQ-014 Tick decrement, visible the next cycle: sec_ones>0 -> sec_ones-1; else sec_tens>0 -> sec_ones=9, sec_tens-1; else minutes nonzero -> seconds=59 and minutes BCD-decremented (min_ones>0 -> min_ones-1, else min_ones=9, min_tens-1).
REQ-015 Count at 00:00 never decrements; no wrap to 99:59.
REQ-016 Entered seconds above 59 (e.g. 00:90) are legal and count down per REQ-014 without normalisation.
REQ-017 Load accepted only when load=1, mag_on=0, clearn=1 and digit<=9; accepted load shifts left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; old min_tens discarded.
REQ-018 Load with mag_on=1 or digit>9 is ignored entirely (digits and prescaler unchanged).
REQ-019 clearn=0 sets all digits and prescaler to 0 that cycle regardless of mag_on or load; done_pulse stays 0.
REQ-020 done_pulse=1 for exactly one cycle, in the cycle after a tick decrement takes the count from nonzero to 00:00; never raised by reset, clear or load.
REQ-021 timer_done reflects the registered digits: deasserts the cycle after a nonzero digit is loaded, asserts in the same cycle as done_pulse.
REQ-022 mag_on falling on the same edge as a tick: the decrement still occurs; later ticks stop.
REQ-023 Simultaneous clearn=0 and tick: clear wins, no decrement, no done_pulse.

Reset
REQ-024 reset=1 immediately forces digits=0, prescaler=0, timer_done=1, done_pulse=0, independent of clk.
REQ-025 Reset asserted mid-countdown aborts the countdown with no done_pulse; after release the block is idle at 00:00.

Verification (TICKS_PER_SEC=4)
REQ-026 Assert reset mid-run -> outputs 00:00, timer_done=1, done_pulse=0 with no clk edge required.
REQ-027 mag_on=0; load 1,3,0 -> 01:30, timer_done=0; then load 4'hA -> unchanged 01:30.
REQ-028 Count 01:00, mag_on=1 -> 00:59 after 4 clk cycles; 00:58 after 8.
REQ-029 Count 00:02, mag_on held 1 -> 00:00 after 8 cycles, done_pulse high exactly one cycle, timer_done stays 1, count stays 00:00 for a further 20 cycles.
REQ-030 Count 00:05, mag_on=1 for 2 cycles, 0 for 10, then 1 -> 00:04 after 2 further cycles; load pulses during mag_on=1 ignored.
REQ-031 Count 00:01, clearn=0 on the tick cycle -> 00:00, done_pulse never asserted.
